// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// controller states and the magnitude / sign-restore helpers used around
// the unsigned iterative datapath.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } mdu_state_t;

    // Helpers work on a container wide enough for a double-width result of
    // the largest supported operand width; callers keep the low bits they need.
    localparam int MDU_MAX_WIDTH = 64;
    typedef logic [2*MDU_MAX_WIDTH-1:0] mdu_wide_t;

    // Signed flavours: MULT, MADD, DIV.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
    endfunction

    // Multiply family (MULT, MULTU, MADD, MADDU) occupies codes 0..3.
    function automatic logic op_is_mul(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Absolute value of a w-bit operand held zero-extended in v. Only the low
    // w bits of the result are meaningful; the most negative value maps onto
    // itself, which reads correctly as an unsigned magnitude.
    function automatic mdu_wide_t magnitude(input mdu_wide_t v, input int w,
                                            input logic is_signed);
        logic neg;
        neg = is_signed && v[w-1];
        return neg ? -v : v;
    endfunction

    // Re-applies a sign to an unsigned magnitude (two's complement negate).
    function automatic mdu_wide_t sign_restore(input mdu_wide_t v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply / divide unit with HI/LO result registers.
// Multiplies use shift-add and divides use restoring division, one step per
// cycle on operand magnitudes; signs and MADD accumulation are applied in the
// FINISH cycle so HI/LO only ever change to a complete result.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdu_state_t state_reg, state_next;

    logic [2:0]       op_reg;
    logic [WIDTH-1:0] work_hi_reg;    // partial product high half / remainder
    logic [WIDTH-1:0] work_lo_reg;    // multiplier bits / dividend -> quotient
    logic [WIDTH-1:0] b_mag_reg;      // multiplicand / divisor magnitude
    logic [CNT_W-1:0] iter_cnt_reg;
    logic             neg_q_reg;      // negate product or quotient at the end
    logic             neg_r_reg;      // negate remainder at the end
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             done_reg, dbz_reg;

    logic accept, zero_div, launch;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   step_hi, step_lo;

    mdu_wide_t          a_mag_wide, b_mag_wide, prod_wide, quo_wide, rem_wide;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix, madd_sum;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    logic unused_wide_bits;

    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

    // Requests are only looked at while idle; zero divisors short-circuit RUN.
    always_comb begin
        accept   = start && (state_reg == ST_IDLE);
        zero_div = op_is_div(op) && (b == '0);
        launch   = accept && (op_is_mul(op) || (op_is_div(op) && !zero_div));
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: WIDTH RUN cycles, then one FINISH cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (launch) state_next = ST_RUN;
            ST_RUN:    if (iter_cnt_reg == LAST_ITER) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Operand magnitudes taken at acceptance from the live inputs.
    always_comb begin
        a_mag_wide = magnitude(mdu_wide_t'(a), WIDTH, op_is_signed(op));
        b_mag_wide = magnitude(mdu_wide_t'(b), WIDTH, op_is_signed(op));
        a_mag      = a_mag_wide[WIDTH-1:0];
        b_mag      = b_mag_wide[WIDTH-1:0];
    end

    // One shift-add or one restoring-divide step on the working registers.
    always_comb begin
        mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, b_mag_reg} : '0);
        div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag_reg};
        div_ok    = ~div_diff[WIDTH];
        if (op_is_div(op_reg)) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {work_lo_reg[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
        end
    end

    // Final sign correction and accumulation, consumed only in FINISH.
    always_comb begin
        prod_wide = sign_restore(mdu_wide_t'({work_hi_reg, work_lo_reg}), neg_q_reg);
        quo_wide  = sign_restore(mdu_wide_t'(work_lo_reg), neg_q_reg);
        rem_wide  = sign_restore(mdu_wide_t'(work_hi_reg), neg_r_reg);
        prod_fix  = prod_wide[2*WIDTH-1:0];
        madd_sum  = {hi_reg, lo_reg} + prod_fix;
        quo_fix   = quo_wide[WIDTH-1:0];
        rem_fix   = rem_wide[WIDTH-1:0];
    end

    // Upper bits of the helper containers are intentionally discarded.
    assign unused_wide_bits = ^{a_mag_wide, b_mag_wide, prod_wide, quo_wide, rem_wide};

    // Datapath, result registers and the done / div_by_zero pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg       <= OP_MULT;
            work_hi_reg  <= '0;
            work_lo_reg  <= '0;
            b_mag_reg    <= '0;
            iter_cnt_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (launch) begin
                        op_reg       <= op;
                        work_hi_reg  <= '0;
                        work_lo_reg  <= a_mag;
                        b_mag_reg    <= b_mag;
                        iter_cnt_reg <= '0;
                        neg_q_reg    <= op_is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_reg    <= op_is_signed(op) && a[WIDTH-1];
                    end else if (accept && zero_div) begin
                        done_reg <= 1'b1;
                        dbz_reg  <= 1'b1;
                    end else if (accept && (op == OP_MTHI)) begin
                        hi_reg   <= a;
                        done_reg <= 1'b1;
                    end else if (accept && (op == OP_MTLO)) begin
                        lo_reg   <= a;
                        done_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    work_hi_reg  <= step_hi;
                    work_lo_reg  <= step_lo;
                    iter_cnt_reg <= iter_cnt_reg + 1'b1;
                end
                ST_FINISH: begin
                    case (op_reg)
                        OP_MULT, OP_MULTU: {hi_reg, lo_reg} <= prod_fix;
                        OP_MADD, OP_MADDU: {hi_reg, lo_reg} <= madd_sum;
                        default: begin
                            lo_reg <= quo_fix;
                            hi_reg <= rem_fix;
                        end
                    endcase
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32: latency, products, MADD
// accumulation, signed/unsigned division, zero divisor, ignored requests,
// back-to-back issue and asynchronous reset abort.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Raise a request at a falling edge; the following rising edge is E0.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Count falling edges until done; inputs are scrambled after acceptance.
    task automatic wait_done(output int cycles, output int busy_cnt, output logic dbz_seen);
        cycles   = 0;
        busy_cnt = 0;
        dbz_seen = 1'b0;
        forever begin
            @(negedge clk);
            cycles++;
            if (busy === 1'b1) busy_cnt++;
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
            op    = 3'($urandom);
            if (done === 1'b1) begin
                dbz_seen = div_by_zero;
                break;
            end
            if (cycles >= 100) break;
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int cycles, output int busy_cnt, output logic dbz_seen);
        issue(o, x, y);
        wait_done(cycles, busy_cnt, dbz_seen);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b cycles=%0d busy=%0d",
                 o, x, y, hi, lo, dbz_seen, cycles, busy_cnt);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL reset_done: got %b want 0", done); end
        n_compared++; if (div_by_zero !== 1'b0) begin n_mismatched++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_compared++; if (lo !== 32'h0) begin n_mismatched++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
        @(negedge clk);
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        $display("reset released");
    endtask

    task automatic test_mult;
        int c, bc; logic z;
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, c, bc, z);
        n_compared++; if (c != 34) begin n_mismatched++; $display("FAIL mult_latency: got %0d want 34", c); end
        n_compared++; if (bc != 33) begin n_mismatched++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
        n_compared++; if (hi !== 32'hFFFF_FFFF) begin n_mismatched++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_compared++; if (lo !== 32'hFFFF_FFEB) begin n_mismatched++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        n_compared++; if (z !== 1'b0) begin n_mismatched++; $display("FAIL mult_dbz: got %b want 0", z); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL mult_busy_in_done: got %b want 0", busy); end
        @(negedge clk);
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL mult_done_width: got %b want 0", done); end
    endtask

    task automatic test_multu_madd;
        int c, bc; logic z;
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, bc, z);
        n_compared++; if (hi !== 32'hFFFF_FFFE) begin n_mismatched++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_compared++; if (lo !== 32'h0000_0001) begin n_mismatched++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        do_op(OP_MTHI, 32'h0, 32'h0, c, bc, z);
        n_compared++; if (c != 1) begin n_mismatched++; $display("FAIL mthi_latency: got %0d want 1", c); end
        n_compared++; if (bc != 0) begin n_mismatched++; $display("FAIL mthi_busy: got %0d want 0", bc); end
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL mthi_hi: got %h want 0", hi); end
        n_compared++; if (lo !== 32'h0000_0001) begin n_mismatched++; $display("FAIL mthi_lo_kept: got %h want 00000001", lo); end
        do_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, c, bc, z);
        n_compared++; if (lo !== 32'hFFFF_FFFF) begin n_mismatched++; $display("FAIL mtlo_lo: got %h want ffffffff", lo); end
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL mtlo_hi_kept: got %h want 0", hi); end
        do_op(OP_MADD, 32'd1, 32'd1, c, bc, z);
        n_compared++; if (hi !== 32'h1) begin n_mismatched++; $display("FAIL madd_hi: got %h want 1", hi); end
        n_compared++; if (lo !== 32'h0) begin n_mismatched++; $display("FAIL madd_lo: got %h want 0", lo); end
        // {1,0} + (-1 * 1) = {0, ffffffff}: signed product sign-extended
        do_op(OP_MADD, 32'hFFFF_FFFF, 32'd1, c, bc, z);
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL madd_neg_hi: got %h want 0", hi); end
        n_compared++; if (lo !== 32'hFFFF_FFFF) begin n_mismatched++; $display("FAIL madd_neg_lo: got %h want ffffffff", lo); end
        // {0, ffffffff} + ffffffff*2 (unsigned) = {2, fffffffd}
        do_op(OP_MADDU, 32'hFFFF_FFFF, 32'd2, c, bc, z);
        n_compared++; if (hi !== 32'h2) begin n_mismatched++; $display("FAIL maddu_hi: got %h want 2", hi); end
        n_compared++; if (lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL maddu_lo: got %h want fffffffd", lo); end
    endtask

    task automatic test_div;
        int c, bc; logic z;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, c, bc, z);
        n_compared++; if (c != 34) begin n_mismatched++; $display("FAIL div_latency: got %0d want 34", c); end
        n_compared++; if (lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL div_neg_q: got %h want fffffffd", lo); end
        n_compared++; if (hi !== 32'hFFFF_FFFF) begin n_mismatched++; $display("FAIL div_neg_r: got %h want ffffffff", hi); end
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, bc, z);
        n_compared++; if (lo !== 32'h8000_0000) begin n_mismatched++; $display("FAIL div_ovf_q: got %h want 80000000", lo); end
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL div_ovf_r: got %h want 0", hi); end
        n_compared++; if (z !== 1'b0) begin n_mismatched++; $display("FAIL div_ovf_dbz: got %b want 0", z); end
        do_op(OP_DIVU, 32'd100, 32'd7, c, bc, z);
        n_compared++; if (lo !== 32'd14) begin n_mismatched++; $display("FAIL divu_q: got %h want 0000000e", lo); end
        n_compared++; if (hi !== 32'd2) begin n_mismatched++; $display("FAIL divu_r: got %h want 2", hi); end
        do_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, c, bc, z);
        n_compared++; if (lo !== 32'h7FFF_FFFC) begin n_mismatched++; $display("FAIL divu_big_q: got %h want 7ffffffc", lo); end
        n_compared++; if (hi !== 32'd1) begin n_mismatched++; $display("FAIL divu_big_r: got %h want 1", hi); end
        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, c, bc, z);
        n_compared++; if (lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL div_negb_q: got %h want fffffffd", lo); end
        n_compared++; if (hi !== 32'd1) begin n_mismatched++; $display("FAIL div_negb_r: got %h want 1", hi); end
    endtask

    task automatic test_div_by_zero;
        int c, bc; logic z;
        // hi=1, lo=fffffffd left by the previous divide
        do_op(OP_DIVU, 32'd5, 32'd0, c, bc, z);
        n_compared++; if (c != 1) begin n_mismatched++; $display("FAIL dbz_latency: got %0d want 1", c); end
        n_compared++; if (bc != 0) begin n_mismatched++; $display("FAIL dbz_busy: got %0d want 0", bc); end
        n_compared++; if (z !== 1'b1) begin n_mismatched++; $display("FAIL dbz_flag: got %b want 1", z); end
        n_compared++; if (hi !== 32'd1) begin n_mismatched++; $display("FAIL dbz_hi_kept: got %h want 1", hi); end
        n_compared++; if (lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL dbz_lo_kept: got %h want fffffffd", lo); end
        @(negedge clk);
        n_compared++; if (div_by_zero !== 1'b0) begin n_mismatched++; $display("FAIL dbz_pulse_width: got %b want 0", div_by_zero); end
        do_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, c, bc, z);
        n_compared++; if (z !== 1'b1) begin n_mismatched++; $display("FAIL dbz_signed_flag: got %b want 1", z); end
        n_compared++; if (lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL dbz_signed_lo: got %h want fffffffd", lo); end
    endtask

    task automatic test_back_to_back;
        int c, bc; logic z;
        issue(OP_MULTU, 32'd3, 32'd5);
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            if (done === 1'b1 || c >= 100) break;
            start = (c == 5);
            op    = OP_MTLO;
            a     = 32'hDEAD_BEEF;
            b     = 32'h0;
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d (mtlo offered while busy)",
                 OP_MULTU, 32'd3, 32'd5, hi, lo, c);
        n_compared++; if (c != 34) begin n_mismatched++; $display("FAIL ignored_latency: got %0d want 34", c); end
        n_compared++; if (lo !== 32'd15) begin n_mismatched++; $display("FAIL ignored_lo: got %h want 0000000f", lo); end
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL ignored_hi: got %h want 0", hi); end
        // Issue the next request in the done cycle itself.
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd6;
        b     = 32'd7;
        wait_done(c, bc, z);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d busy=%0d (back-to-back)",
                 OP_MULT, 32'd6, 32'd7, hi, lo, c, bc);
        n_compared++; if (c != 34) begin n_mismatched++; $display("FAIL b2b_latency: got %0d want 34", c); end
        n_compared++; if (bc != 33) begin n_mismatched++; $display("FAIL b2b_busy: got %0d want 33", bc); end
        n_compared++; if (lo !== 32'd42) begin n_mismatched++; $display("FAIL b2b_lo: got %h want 0000002a", lo); end
    endtask

    task automatic test_reset_abort;
        int c, bc, pulses; logic z;
        do_op(OP_MTHI, 32'h1234_5678, 32'h0, c, bc, z);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (11) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        $display("reset asserted mid-operation: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL abort_done: got %b want 0", done); end
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL abort_hi: got %h want 0", hi); end
        n_compared++; if (lo !== 32'h0) begin n_mismatched++; $display("FAIL abort_lo: got %h want 0", lo); end
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_compared++; if (pulses != 0) begin n_mismatched++; $display("FAIL abort_no_done: got %0d active cycles want 0", pulses); end
        do_op(OP_MULT, 32'd6, 32'd7, c, bc, z);
        n_compared++; if (c != 34) begin n_mismatched++; $display("FAIL post_abort_latency: got %0d want 34", c); end
        n_compared++; if (lo !== 32'd42) begin n_mismatched++; $display("FAIL post_abort_lo: got %h want 0000002a", lo); end
        n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("FAIL post_abort_hi: got %h want 0", hi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_madd();
        test_div();
        test_div_by_zero();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
